rot_feeder: RTL and testbench
=============================

Name: rot_feeder

Overview:
- Sequential front-end that streams N-bit words into the combinational rot block and captures its results.
- Per-word rotation amount comes from a programmable arithmetic sequence: k0, k0+step, k0+2*step, ... (mod N).
- Owns the valid/ready handshakes on both sides and a 2-entry output buffer, so the combinational rotator sits between registered boundaries.

Parameters:
N, 8, word width in bits; must be a power of two
log2_N, 3, width of rotation amount; N = 2^log2_N

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_load  input  1  start a new burst (sampled only in IDLE)
cfg_k0  input  [0:log2_N-1]  initial rotation amount
cfg_step  input  [0:log2_N-1]  per-word rotation increment
in_valid  input  1  input word valid
in_ready  output  1  feeder accepts input word this cycle
in_data  input  [0:N-1]  input word
in_last  input  1  marks final word of burst
rot_bits  output  [0:N-1]  word driven to rot block
rot_k  output  [0:log2_N-1]  rotation amount driven to rot block
rot_result  input  [0:N-1]  rotated word returned by rot block
out_valid  output  1  output buffer non-empty
out_ready  input  1  downstream accepts head entry
out_data  output  [0:N-1]  rotated word at buffer head
out_k  output  [0:log2_N-1]  rotation amount used for out_data
out_last  output  1  last flag of head entry
busy  output  1  state != IDLE

Behaviour:
- Rotation convention: rot_result[i] = rot_bits[(i - rot_k) mod N]. Indices are ascending [0:N-1]; k[0] is the MSB and weighs N/2.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: if cfg_load=1, latch cfg_k0 into cur_k and cfg_step into step_r, then go to RUN.
  - RUN: accept words. Go to DRAIN on the cycle a word with in_last=1 is accepted.
  - DRAIN: go to IDLE when the buffer is empty and no pop is pending (count==0).
- cfg_load is ignored in RUN and DRAIN. cur_k and step_r do not change in those states except by the increment rule below.
- in_ready = (state==RUN) && (count<2). It is combinational from registered state only; it never depends on out_ready.
- Accept occurs when in_valid && in_ready.
- rot_bits = in_data and rot_k = cur_k at all times (combinational pass-through).
- On accept:
  - Push {rot_result, cur_k, in_last} into the buffer in the same cycle.
  - cur_k <= (cur_k + step_r) mod N. The sum truncates to log2_N bits, so wrap-around is natural.
- Output buffer: 2-entry FIFO with count in 0..2.
  - out_valid = (count!=0). out_data, out_k and out_last come from the head entry.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged and preserves order.
  - Push when count==2 cannot occur, because in_ready is low.
- Latency: a word accepted in cycle t is visible on out_data in cycle t+1.
- Throughput: 1 word/cycle when out_ready is held high.
- Output entries are stable while out_valid=1 and out_ready=0.
- busy = (state != IDLE).
- Reset (any time, including mid-burst): state=IDLE, count=0 (buffer contents discarded), cur_k=0, step_r=0. Resulting outputs: in_ready=0, out_valid=0, out_data=0, out_k=0, out_last=0, busy=0.
- in_valid while in IDLE or DRAIN: no accept, no state change.
- step_r=0: every word in the burst uses k0.

Test Plan:
- Reset, then cfg_k0=1, cfg_step=0, cfg_load=1; send in_data=10000000 with in_last=1 -> out_data=01000000 and out_k=1 one cycle after accept; out_last=1; FSM returns to IDLE; busy=0.
- cfg_k0=0, cfg_step=3; four words 10000000 with last on the 4th; out_ready=1 -> out_k sequence 0,3,6,1 (wrap); out_data sequence 10000000, 00010000, 00000010, 01000000; one word per cycle.
- Backpressure: out_ready=0, in_valid=1 in RUN -> exactly 2 accepts, then in_ready=0; head holds stable; raise out_ready -> order preserved, no loss or duplication.
- Simultaneous push/pop at count==1 with out_ready=1 -> count stays 1 and the output stream matches the input order.
- cfg_load pulsed in RUN with different k0 -> ignored; cur_k sequence continues unchanged.
- Assert rst_n=0 mid-burst with count==2 -> out_valid=0, in_ready=0, busy=0 immediately (async); after release a new cfg_load burst starts at the new cfg_k0.

Source files
------------

// File: rtl/rot_feeder.sv
// Streaming front-end for the combinational rot block: feeds words with an
// arithmetic-sequence rotation amount and captures results in a 2-entry FIFO.
module rot_feeder #(
   parameter int unsigned N      = 8,
   parameter int unsigned log2_N = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_load,
   input  logic [0:log2_N-1] cfg_k0,
   input  logic [0:log2_N-1] cfg_step,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:N-1]      in_data,
   input  logic              in_last,
   output logic [0:N-1]      rot_bits,
   output logic [0:log2_N-1] rot_k,
   input  logic [0:N-1]      rot_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:N-1]      out_data,
   output logic [0:log2_N-1] out_k,
   output logic              out_last,
   output logic              busy
);

   localparam int unsigned KW = log2_N;
   localparam int unsigned DW = N;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [1:0]    count;
   logic [KW-1:0] cur_k;
   logic [KW-1:0] step_r;
   logic [DW-1:0] e0_data, e1_data;
   logic [KW-1:0] e0_k, e1_k;
   logic          e0_last, e1_last;
   logic          accept;
   logic          pop;

   // Handshake terms depend only on registered state and count
   assign in_ready  = (state == RUN) && (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign busy      = (state != IDLE);

   assign rot_bits = in_data;
   assign rot_k    = cur_k;

   assign out_data = e0_data;
   assign out_k    = e0_k;
   assign out_last = e0_last;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_load) state_nxt = RUN;
         RUN:     if (accept && in_last) state_nxt = DRAIN;
         DRAIN:   if (count == 2'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Rotation sequence: latched at burst start, advanced once per accepted word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_k  <= '0;
         step_r <= '0;
      end else if ((state == IDLE) && cfg_load) begin
         cur_k  <= cfg_k0;
         step_r <= cfg_step;
      end else if (accept) begin
         cur_k <= cur_k + step_r;
      end
   end

   // Two-entry FIFO with e0 as the head; push at count==2 is excluded by in_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= 2'd0;
         e0_data <= '0;
         e0_k    <= '0;
         e0_last <= 1'b0;
         e1_data <= '0;
         e1_k    <= '0;
         e1_last <= 1'b0;
      end else if (pop && !accept) begin
         e0_data <= e1_data;
         e0_k    <= e1_k;
         e0_last <= e1_last;
         count   <= count - 2'd1;
      end else if (accept && !pop) begin
         if (count == 2'd0) begin
            e0_data <= rot_result;
            e0_k    <= cur_k;
            e0_last <= in_last;
         end else begin
            e1_data <= rot_result;
            e1_k    <= cur_k;
            e1_last <= in_last;
         end
         count <= count + 2'd1;
      end else if (accept && pop) begin
         if (count == 2'd1) begin
            e0_data <= rot_result;
            e0_k    <= cur_k;
            e0_last <= in_last;
         end else begin
            e0_data <= e1_data;
            e0_k    <= e1_k;
            e0_last <= e1_last;
            e1_data <= rot_result;
            e1_k    <= cur_k;
            e1_last <= in_last;
         end
      end
   end

endmodule

// File: tb/tb_rot_feeder.sv
// Bench for rot_feeder: models the rot block and checks the feeder against a
// queue-based cycle model built from the handshake and rotation rules.
module tb_rot_feeder;

   localparam int unsigned N  = 8;
   localparam int unsigned LK = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_load;
   logic [0:LK-1] cfg_k0, cfg_step;
   logic          in_valid, in_ready;
   logic [0:N-1]  in_data;
   logic          in_last;
   logic [0:N-1]  rot_bits;
   logic [0:LK-1] rot_k;
   logic [0:N-1]  rot_result;
   logic          out_valid, out_ready;
   logic [0:N-1]  out_data;
   logic [0:LK-1] out_k;
   logic          out_last;
   logic          busy;

   always #5 clk = ~clk;

   rot_feeder #(.N(N), .log2_N(LK)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_k0(cfg_k0),
      .cfg_step(cfg_step), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .rot_bits(rot_bits),
      .rot_k(rot_k), .rot_result(rot_result), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_k(out_k),
      .out_last(out_last), .busy(busy)
   );

   // External rot block: result[i] = bits[(i - k) mod N], ascending indices
   always_comb begin
      rot_result = '0;
      for (int i = 0; i < int'(N); i++)
         rot_result[i] = rot_bits[(i + int'(N) - int'(rot_k)) % int'(N)];
   end

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] k;
      logic       l;
   } ent_t;

   ent_t       q[$];
   int         ph;      // 0 idle, 1 run, 2 drain
   logic [2:0] mk, ms;
   int         tests = 0;
   int         fails = 0;
   logic       acc;

   // Bit 0 is the MSB, so moving bit i to i+k is a numeric right rotate
   function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] k);
      int v, s;
      v = int'(x);
      s = int'(k);
      return 8'((v >> s) | (v << (int'(N) - s)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      ph = 0;
      mk = 3'd0;
      ms = 3'd0;
   endtask

   // One clock: check outputs against the model, drive inputs, advance the model
   task automatic step(input logic iv, input logic [7:0] d, input logic lst,
                       input logic ordy, input logic ld, input logic [2:0] k0,
                       input logic [2:0] st, output logic a);
      logic   rdy, pp;
      int     nph;
      @(negedge clk);
      rdy = (ph == 1) && (q.size() < 2);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rot_k", 32'(rot_k), 32'(mk));
      if (q.size() != 0) begin
         chk("out_data", 32'(out_data), 32'(q[0].d));
         chk("out_k", 32'(out_k), 32'(q[0].k));
         chk("out_last", 32'(out_last), 32'(q[0].l));
      end
      in_valid  = iv;
      in_data   = d;
      in_last   = lst;
      out_ready = ordy;
      cfg_load  = ld;
      cfg_k0    = k0;
      cfg_step  = st;
      #1;
      chk("rot_bits", 32'(rot_bits), 32'(d));
      a  = iv && rdy;
      pp = (q.size() != 0) && ordy;
      nph = ph;
      if (ph == 0 && ld) nph = 1;
      if (ph == 1 && a && lst) nph = 2;
      if (ph == 2 && q.size() == 0) nph = 0;
      if (pp) void'(q.pop_front());
      if (a) begin
         q.push_back('{d: rotr(d, mk), k: mk, l: lst});
         mk = 3'(mk + ms);
      end
      if (ph == 0 && ld) begin
         mk = k0;
         ms = st;
      end
      ph = nph;
   endtask

   task automatic load(input logic [2:0] k0, input logic [2:0] st);
      logic a;
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, k0, st, a);
   endtask

   // Drain with stray in_valid that must not be accepted outside RUN
   task automatic drain();
      logic a;
      for (int i = 0; i < 20 && ph != 0; i++)
         step(1'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0, 3'($urandom), 3'($urandom), a);
      if (ph != 0) chk("drain_timeout", 32'(busy), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] t2_d [4];
      logic [2:0] t2_k [4];
      t2_d = '{8'h80, 8'h10, 8'h02, 8'h40};
      t2_k = '{3'd0, 3'd3, 3'd6, 3'd1};

      rst_n = 1'b0; cfg_load = 1'b0; cfg_k0 = '0; cfg_step = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      model_reset();
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_k", 32'(out_k), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single word, k0=1, step=0
      load(3'd1, 3'd0);
      step(1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 3'd5, 3'd5, acc);
      @(posedge clk); #1;
      chk("t1_data", 32'(out_data), 32'h40);
      chk("t1_k", 32'(out_k), 32'd1);
      chk("t1_last", 32'(out_last), 32'd1);
      drain();

      // Four words, k sequence wraps 0,3,6,1, one word per cycle
      load(3'd0, 3'd3);
      for (int j = 0; j < 4; j++) begin
         step(1'b1, 8'h80, 1'(j == 3), 1'b1, 1'b0, 3'd0, 3'd0, acc);
         @(posedge clk); #1;
         chk("t2_data", 32'(out_data), 32'(t2_d[j]));
         chk("t2_k", 32'(out_k), 32'(t2_k[j]));
      end
      drain();

      // Backpressure: only two accepts while out_ready is low
      load(3'd2, 3'd1);
      for (int j = 0; j < 4; j++)
         step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, acc);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      for (int j = 0; j < 2; j++)
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      drain();

      // cfg_load during RUN is ignored
      load(3'd0, 3'd1);
      step(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      step(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 3'd5, 3'd4, acc);
      step(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      drain();

      // Async reset mid-burst with a full buffer
      load(3'd3, 3'd2);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, acc);
      step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, acc);
      @(negedge clk); #2;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      load(3'd6, 3'd2);
      step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      @(posedge clk); #1;
      chk("post_rst_k", 32'(out_k), 32'd6);
      step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      drain();

      // Randomized bursts with random valid and backpressure
      for (int b = 0; b < 8; b++) begin
         int len, w;
         len = int'($urandom_range(1, 7));
         w = 0;
         load(3'($urandom), 3'($urandom));
         for (int c = 0; c < 80 && w < len; c++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'(w == len - 1),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 3'($urandom), acc);
            if (acc) w++;
         end
         if (w < len) chk("burst_timeout", 32'(w), 32'(len));
         drain();
         step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, acc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
